// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bundle used by program_loader.
// The loader connects to the slave modport; the byte source and memory model connect to master.
interface program_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_din
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/program_loader.sv
// Serial program loader: packs a counted byte frame into 32-bit words, writes instruction memory
// and holds the CPU in reset until the load completes. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.slave   bus,
  input  logic              reload,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    CNT_HI = 3'd0,
    CNT_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t            state, nxt;
  logic [7:0]        count_hi;
  logic [15:0]       cnt_full;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        byte_idx;
  logic [23:0]       word;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_din_r;
  logic              rx_ready_c;
  logic              acc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // Handshake: a byte transfers on a rising edge where rx_valid and rx_ready are both high;
  // rx_ready depends only on state and reset, never on rx_valid.
  assign acc          = bus.rx_valid & rx_ready_c;
  assign cnt_full     = {count_hi, bus.rx_data};
  assign bus.rx_ready = rx_ready_c;
  assign bus.mem_we   = mem_we_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_din  = mem_din_r;
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (reset) state <= CNT_HI;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      CNT_HI: if (acc) nxt = CNT_LO;
      CNT_LO: if (acc) nxt = (cnt_full == 16'd0 || cnt_full > DEPTH16) ? ERR : DATA;
      DATA: begin
        if (acc && byte_idx == 2'd3 && widx == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
          nxt = CHK;
`else
          nxt = FLUSH;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      // csum already includes the final payload byte by the time CHK samples a byte.
      CHK: if (acc) nxt = (bus.rx_data == csum) ? DONE : ERR;
`endif
      // Holds one cycle so done rises only after the final write is visible.
      FLUSH: nxt = DONE;
      DONE, ERR: if (reload) nxt = CNT_HI;
      default: nxt = CNT_HI;
    endcase
  end

  always_comb begin
    rx_ready_c = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    case (state)
      CNT_HI, CNT_LO, DATA, CHK: rx_ready_c = !reset;
      DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      ERR: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_hi     <= '0;
      last_idx     <= '0;
      widx         <= '0;
      byte_idx     <= '0;
      word         <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_din_r    <= '0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we_r <= 1'b0;
      if (acc) begin
        case (state)
          CNT_HI: count_hi <= bus.rx_data;
          CNT_LO: begin
            last_idx <= ADDR_W'(cnt_full - 16'd1);
            widx     <= '0;
            byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
          DATA: begin
            word     <= {word[15:0], bus.rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.rx_data;
`endif
            if (byte_idx == 2'd3) begin
              mem_we_r     <= 1'b1;
              mem_addr_r   <= widx;
              mem_din_r    <= {word, bus.rx_data};
              widx         <= widx + ADDR_W'(1);
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end
          end
          default: ;
        endcase
      end
      if ((state == DONE || state == ERR) && reload) words_loaded <= '0;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, stalls, count errors, reset abort and reload.
module tb_program_loader;
  localparam int ADDR_W = 10;
  localparam int W      = ADDR_W + 32;

  logic            clk;
  logic            reset;
  logic            reload;
  logic            cpu_reset;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;
  logic [2:0]      state_dbg;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .DEPTH(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .reload       (reload),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int last_we_cyc  = -1;
  int done_rise_cyc = -1;
  int cpu_fall_cyc  = -1;
  logic done_prev = 1'b0;
  logic cpu_prev  = 1'b1;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  wr_q[$];
  logic [31:0]   frame_q[$];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum_flip = 8'h00;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/edge monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_q.push_back({bus.mem_addr, bus.mem_din});
      last_we_cyc <= cyc;
    end
    if (done === 1'b1 && done_prev === 1'b0) done_rise_cyc <= cyc;
    if (cpu_reset === 1'b0 && cpu_prev === 1'b1) cpu_fall_cyc <= cyc;
    done_prev <= done;
    cpu_prev  <= cpu_reset;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    step();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1 for byte %h", bus.rx_ready, b);
    end
  endtask

  task automatic rx_release();
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap_max);
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  b;
    n = 16'(frame_q.size());
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < frame_q.size(); i++) begin
      w = frame_q[i];
      exp_q.push_back({ADDR_W'(i), w});
      for (int k = 3; k >= 0; k--) begin
        b = w[k*8 +: 8];
        if (gap_max > 0) begin
          repeat ($urandom_range(0, gap_max)) begin
            step();
            bus.rx_valid = 1'b0;
          end
        end
        send_byte(b);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    b = csum_flip;
    for (int i = 0; i < frame_q.size(); i++) begin
      w = frame_q[i];
      b = b ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    send_byte(b);
`endif
    rx_release();
    frame_q.delete();
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_end_timeout: done=%b error=%b required one of them 1", done, error);
    end
  endtask

  task automatic pulse_reload();
    step();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    reload = 1'b0;
    repeat (3) step();
    tests_run++;
    if (bus.rx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_ready: got %b required 0", bus.rx_ready); end
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    tests_run++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_din !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mem: got we=%b addr=%h din=%h required 0/0/0", bus.mem_we, bus.mem_addr, bus.mem_din);
    end
    tests_run++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: got cpu_reset=%b done=%b error=%b required 1/0/0", cpu_reset, done, error);
    end
    tests_run++;
    if (words_loaded !== '0 || state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_count_state: got words=%0d state=%0d required 0/0", words_loaded, state_dbg);
    end
  endtask

  task automatic test_single_word();
    logic seen_ready;
    logic [W-1:0] o, e;
    frame_q.push_back(32'h12345678);
    send_frame(0);
    wait_end();
    step();
    tests_run++;
    if (wr_q.size() !== 1) begin tests_failed++; $display("FAIL single_wr_count: got %0d required 1", wr_q.size()); end
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front();
      o = wr_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL single_wr_data: got %h required %h", o, e); end
    end
    exp_q.delete();
    wr_q.delete();
    tests_run++;
    if (done_rise_cyc !== last_we_cyc + 1) begin
      tests_failed++;
      $display("FAIL single_done_latency: got done cycle %0d required %0d", done_rise_cyc, last_we_cyc + 1);
    end
    tests_run++;
    if (cpu_fall_cyc !== done_rise_cyc) begin
      tests_failed++;
      $display("FAIL single_cpu_release: got cpu_reset fall cycle %0d required %0d", cpu_fall_cyc, done_rise_cyc);
    end
    tests_run++;
    if (words_loaded !== 11'd1 || done !== 1'b1 || cpu_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_final: got words=%0d done=%b cpu_reset=%b required 1/1/0", words_loaded, done, cpu_reset);
    end
    // Extra bytes after the frame must be refused.
    seen_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    repeat (3) begin
      step();
      if (bus.rx_ready !== 1'b0) seen_ready = 1'b1;
    end
    bus.rx_valid = 1'b0;
    step();
    tests_run++;
    if (seen_ready !== 1'b0 || wr_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL extra_byte_refused: got ready_seen=%b writes=%0d required 0/0", seen_ready, wr_q.size());
    end
  endtask

  task automatic test_reload();
    logic seen_ready;
    logic [W-1:0] o, e;
    seen_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (3) begin
      step();
      if (bus.rx_ready !== 1'b0) seen_ready = 1'b1;
    end
    bus.rx_valid = 1'b0;
    tests_run++;
    if (seen_ready !== 1'b0) begin tests_failed++; $display("FAIL done_refuses_bytes: got ready_seen=%b required 0", seen_ready); end
    pulse_reload();
    tests_run++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || words_loaded !== '0 || state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL reload_clear: got cpu_reset=%b done=%b words=%0d state=%0d required 1/0/0/0",
               cpu_reset, done, words_loaded, state_dbg);
    end
    frame_q.push_back(32'hCAFEBABE);
    send_frame(0);
    wait_end();
    step();
    tests_run++;
    if (wr_q.size() !== 1) begin tests_failed++; $display("FAIL reload_wr_count: got %0d required 1", wr_q.size()); end
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front();
      o = wr_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL reload_wr_data: got %h required %h", o, e); end
    end
    exp_q.delete();
    wr_q.delete();
    tests_run++;
    if (done !== 1'b1 || words_loaded !== 11'd1) begin
      tests_failed++;
      $display("FAIL reload_final: got done=%b words=%0d required 1/1", done, words_loaded);
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] o, e;
    pulse_reload();
    frame_q.push_back(32'h01020304);
    frame_q.push_back(32'hA5A55A5A);
    frame_q.push_back(32'hDEADBEEF);
    send_frame(3);
    wait_end();
    step();
    tests_run++;
    if (wr_q.size() !== 3) begin tests_failed++; $display("FAIL gaps_wr_count: got %0d required 3", wr_q.size()); end
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front();
      o = wr_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL gaps_wr_data: got %h required %h", o, e); end
    end
    exp_q.delete();
    wr_q.delete();
    tests_run++;
    if (words_loaded !== 11'd3 || done !== 1'b1 || cpu_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL gaps_final: got words=%0d done=%b cpu_reset=%b required 3/1/0", words_loaded, done, cpu_reset);
    end
  endtask

  task automatic test_count_errors();
    logic [15:0] bad_counts [2];
    bad_counts[0] = 16'h0000;
    bad_counts[1] = 16'h0401;
    for (int i = 0; i < 2; i++) begin
      pulse_reload();
      send_byte(bad_counts[i][15:8]);
      send_byte(bad_counts[i][7:0]);
      rx_release();
      wait_end();
      repeat (3) step();
      tests_run++;
      if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL count_err_%h: got error=%b cpu_reset=%b done=%b required 1/1/0",
                 bad_counts[i], error, cpu_reset, done);
      end
      tests_run++;
      if (wr_q.size() !== 0 || bus.rx_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL count_err_quiet_%h: got writes=%0d rx_ready=%b required 0/0",
                 bad_counts[i], wr_q.size(), bus.rx_ready);
      end
      wr_q.delete();
    end
  endtask

  task automatic test_reset_midload();
    logic [W-1:0] o, e;
    pulse_reload();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    step();
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    step();
    tests_run++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_din !== 32'h0 || bus.rx_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_mem: got we=%b addr=%h din=%h ready=%b required 0/0/0/0",
               bus.mem_we, bus.mem_addr, bus.mem_din, bus.rx_ready);
    end
    tests_run++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== '0 || state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL midreset_status: got cpu_reset=%b done=%b error=%b words=%0d state=%0d required 1/0/0/0/0",
               cpu_reset, done, error, words_loaded, state_dbg);
    end
    reset = 1'b0;
    wr_q.delete();
    frame_q.push_back(32'hAABBCCDD);
    send_frame(1);
    wait_end();
    step();
    tests_run++;
    if (wr_q.size() !== 1 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_reload: got writes=%0d done=%b required 1/1", wr_q.size(), done);
    end
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front();
      o = wr_q.pop_front();
      tests_run++;
      if (o !== e) begin tests_failed++; $display("FAIL midreset_wr_data: got %h required %h", o, e); end
    end
    exp_q.delete();
    wr_q.delete();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    pulse_reload();
    csum_flip = 8'h01;
    frame_q.push_back(32'h12345678);
    send_frame(0);
    csum_flip = 8'h00;
    wait_end();
    step();
    tests_run++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL csum_bad: got error=%b cpu_reset=%b done=%b required 1/1/0", error, cpu_reset, done);
    end
    tests_run++;
    if (wr_q.size() !== 1) begin tests_failed++; $display("FAIL csum_bad_writes: got %0d required 1", wr_q.size()); end
    exp_q.delete();
    wr_q.delete();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reload       = 1'b0;
    reset        = 1'b1;
    test_reset();
    test_single_word();
    test_reload();
    test_gaps();
    test_count_errors();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
